serial_sub_ctrl: RTL and testbench
==================================

// Module: serial_sub_ctrl
// PURPOSE
//  Bit-serial WIDTH-bit subtractor controller: computes diff = a - b - bin by sequencing one
//  1-bit full-subtractor cell LSB-first, one bit per clock, with a registered borrow chain.
//  Sits between a requester using a start/busy/done handshake and the single-bit datapath,
//  trading WIDTH cycles of latency for a single full-subtractor cell.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range 2..64
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      request; sampled only in IDLE
//  a          in   WIDTH  minuend, captured on accepted start
//  b          in   WIDTH  subtrahend, captured on accepted start
//  bin        in   1      borrow-in, captured on accepted start
//  busy       out  1      high in SHIFT state
//  done       out  1      one-cycle pulse: diff/bout valid from this cycle
//  diff       out  WIDTH  result a - b - bin (mod 2^WIDTH), held until next completion
//  bout       out  1      final borrow-out (1 = unsigned a < b + bin)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; busy=0, done=0, diff=0, bout=0; shift regs, borrow reg,
//    bit counter cleared. Reset mid-operation aborts; no done pulse for the aborted request.
//  - Cell equations per bit i: d = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (br & ~(a_i ^ b_i)).
//  - States: IDLE, SHIFT, DONE.
//    IDLE : start=1 at edge E0 -> load a_sr=a, b_sr=b, br=bin, cnt=0, res_sr=0 -> SHIFT.
//           Also latch a[WIDTH-1], b[WIDTH-1] for optional overflow.
//    SHIFT: each edge: res_sr <= {d, res_sr[WIDTH-1:1]}; a_sr, b_sr shift right 1;
//           br <= br_next; cnt <= cnt+1. On the edge where cnt==WIDTH-1 (edge E0+WIDTH):
//           diff <= {d, res_sr[WIDTH-1:1]}, bout <= br_next, done <= 1 -> DONE.
//    DONE : done=1 for exactly this cycle; next edge -> IDLE, done <= 0. start ignored here.
//  - Latency: start sampled at edge E0 -> done high in cycle after edge E0+WIDTH; busy high
//    in cycles after edges E0..E0+WIDTH-1 (WIDTH cycles). Minimum issue interval WIDTH+2.
//  - start while busy=1 or in DONE: ignored, not queued; a/b/bin changes ignored after capture.
//  - diff/bout change only on the completion edge; never cleared by a new start.
//  - Counter width $clog2(WIDTH); no wrap other than reload on accepted start.
//  - Arithmetic is modulo 2^WIDTH; bout is the borrow out of bit WIDTH-1.
// CONFIGURATION
//  Macro SERIAL_SUB_OVF_EN:
//   defined : adds output port ovf (1 bit, reset 0), updated with diff on completion edge:
//             ovf = (a_msb ^ b_msb) & (a_msb ^ diff[WIDTH-1]) using latched operand MSBs;
//             signed two's-complement overflow of a - b - bin.
//   undefined: port ovf and MSB latches absent; all other behaviour identical.
// TESTING
//  1. WIDTH=8, a=0x5A b=0x3C bin=0, start 1 cycle -> busy 8 cycles, done in cycle 9 after
//     start edge, diff=0x1E bout=0.
//  2. a=0x00 b=0x01 bin=0 -> diff=0xFF bout=1 (ovf=0 when SERIAL_SUB_OVF_EN).
//  3. a=0x10 b=0x0F bin=1 -> diff=0x00 bout=0; then a=0x00 b=0x00 bin=1 -> diff=0xFF bout=1.
//  4. start held high continuously with changing a/b -> only operands at accepted edges used,
//     done every 10 cycles, no restart mid-SHIFT; diff holds between pulses.
//  5. Assert rst_n=0 at 4th SHIFT cycle -> busy/done/diff/bout=0 immediately, no done pulse;
//     after release, a=0x03 b=0x05 -> diff=0xFE bout=1.
//  6. SERIAL_SUB_OVF_EN: a=0x80 b=0x01 bin=0 -> diff=0x7F bout=0 ovf=1; a=0x7F b=0xFF ->
//     diff=0x80 bout=1 ovf=1; a=0x05 b=0x03 -> ovf=0.

Source files
------------

// File: rtl/serial_sub_ctrl_if.sv
// Request/response bundle for the bit-serial subtractor controller.
// SERIAL_SUB_OVF_EN adds the signed-overflow flag.
interface serial_sub_ctrl_if #(parameter int WIDTH = 8);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;

   modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
   modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
`else
   modport master (output start, a, b, bin, input busy, done, diff, bout);
   modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b - bin: one full-subtractor cell, LSB first, one bit per clock.
// Optional SERIAL_SUB_OVF_EN adds a signed-overflow output.
module serial_sub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   serial_sub_ctrl_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr, diff_q;
   logic [CW-1:0]    cnt;
   logic             br, bout_q;
   logic             d, br_nx, load, last;
`ifdef SERIAL_SUB_OVF_EN
   logic             a_msb, b_msb, ovf_q;
`endif

   // Single full-subtractor cell on the current LSBs
   always_comb begin
      d     = a_sr[0] ^ b_sr[0] ^ br;
      br_nx = (~a_sr[0] & b_sr[0]) | (br & ~(a_sr[0] ^ b_sr[0]));
   end

   assign last = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      case (state)
         IDLE: if (bus.start) begin
            load     = 1'b1;
            state_nx = SHIFT;
         end
         SHIFT: if (last) state_nx = DONE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         diff_q <= '0;
         cnt    <= '0;
         br     <= 1'b0;
         bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         ovf_q  <= 1'b0;
`endif
      end else if (load) begin
         a_sr   <= bus.a;
         b_sr   <= bus.b;
         br     <= bus.bin;
         res_sr <= '0;
         cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb  <= bus.a[WIDTH-1];
         b_msb  <= bus.b[WIDTH-1];
`endif
      end else if (state == SHIFT) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         res_sr <= {d, res_sr[WIDTH-1:1]};
         br     <= br_nx;
         // Counter parks at WIDTH-1; only a new start reloads it
         if (!last) cnt <= cnt + CW'(1);
         if (last) begin
            diff_q <= {d, res_sr[WIDTH-1:1]};
            bout_q <= br_nx;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q  <= (a_msb ^ b_msb) & (a_msb ^ d);
`endif
         end
      end
   end

   assign bus.busy = (state == SHIFT);
   assign bus.done = (state == DONE);
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
   assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: vector table, scoreboard, and corner sequences.
// Checks ovf as well when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub_ctrl;
   localparam int W = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   serial_sub_ctrl_if #(.WIDTH(W)) bus();

   serial_sub_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] d;
      logic         bo;
      logic         ov;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      logic [W-1:0] d;
      logic         bo;
      logic         ov;
   } vec_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   last_done = -1;
   int   done_cnt = 0;
   bit   spacing_en = 0;
   bit   hold_en = 0;
   logic [W-1:0] last_d = '0;
   logic         last_bo = 1'b0;
   logic         last_ov = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      exp_t         e;
      logic [W:0]   t;
      t    = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
      e.d  = t[W-1:0];
      e.bo = t[W];
      e.ov = (a[W-1] ^ b[W-1]) & (a[W-1] ^ e.d[W-1]);
      return e;
   endfunction

   // Scoreboard: pop on every done pulse; between pulses results must hold
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (bus.done) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            check("done_unexpected", bus.done, 1'b0);
         end else begin
            e = exp_q.pop_front();
            check("diff", bus.diff, e.d);
            check("bout", bus.bout, e.bo);
`ifdef SERIAL_SUB_OVF_EN
            check("ovf", bus.ovf, e.ov);
`endif
            last_d  = e.d;
            last_bo = e.bo;
            last_ov = e.ov;
         end
         if (spacing_en && last_done >= 0) check("done_spacing", cyc - last_done, W + 2);
         last_done = cyc;
      end else if (hold_en) begin
         check("diff_hold", bus.diff, last_d);
         check("bout_hold", bus.bout, last_bo);
`ifdef SERIAL_SUB_OVF_EN
         check("ovf_hold", bus.ovf, last_ov);
`endif
      end
   end

   // One request; also pokes start mid-SHIFT and in DONE, which must be ignored
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         input exp_t e);
      int bcnt;
      int done_at;
      bcnt    = 0;
      done_at = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.bin   = bin;
      @(posedge clk);
      exp_q.push_back(e);
      for (int k = 1; k <= W + 4; k++) begin
         @(negedge clk);
         if (k == 1) begin
            bus.start = 1'b0;
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            bus.bin   = 1'($urandom);
         end
         if (k == 3) bus.start = 1'b1;
         if (k == 4) bus.start = 1'b0;
         if (bus.busy) bcnt++;
         if (bus.done) begin
            done_at   = k;
            bus.start = 1'b1;
            break;
         end
      end
      check("done_latency", done_at, W + 1);
      check("busy_cycles", bcnt, W);
      @(negedge clk);
      check("done_one_cycle", bus.done, 1'b0);
      check("idle_after_done", bus.busy, 1'b0);
      bus.start = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[10];
      exp_t e;
      int   dc0;

      tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
      tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
      tbl[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
      tbl[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
      tbl[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
      tbl[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
      tbl[6] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
      tbl[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      tbl[8] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0};
      tbl[9] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};

      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.bin   = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_done", bus.done, 1'b0);
      check("rst_diff", bus.diff, '0);
      check("rst_bout", bus.bout, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
      check("rst_ovf", bus.ovf, 1'b0);
`endif
      rst_n   = 1'b1;
      hold_en = 1'b1;

      foreach (tbl[i]) begin
         e.d  = tbl[i].d;
         e.bo = tbl[i].bo;
         e.ov = tbl[i].ov;
         run_op(tbl[i].a, tbl[i].b, tbl[i].bin, e);
      end

      for (int i = 0; i < 6; i++) begin
         logic [W-1:0] ra, rb;
         logic         rc;
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         run_op(ra, rb, rc, model(ra, rb, rc));
      end

      // start held high: accepted every W+2 edges, operands sampled only then
      dc0        = done_cnt;
      spacing_en = 1'b1;
      last_done  = -1;
      for (int n = 0; n < 3 * (W + 2); n++) begin
         logic [W-1:0] ha, hb;
         logic         hc;
         ha = W'($urandom);
         hb = W'($urandom);
         hc = 1'($urandom);
         @(negedge clk);
         bus.start = 1'b1;
         bus.a     = ha;
         bus.b     = hb;
         bus.bin   = hc;
         @(posedge clk);
         if (n % (W + 2) == 0) exp_q.push_back(model(ha, hb, hc));
      end
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      spacing_en = 1'b0;
      check("held_done_count", done_cnt - dc0, 3);
      check("held_queue_drained", exp_q.size(), 0);

      // Reset in the 4th SHIFT cycle aborts with no done pulse
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 8'h12;
      bus.b     = 8'h34;
      bus.bin   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      check("busy_before_reset", bus.busy, 1'b1);
      hold_en = 1'b0;
      rst_n   = 1'b0;
      #1;
      check("abort_busy", bus.busy, 1'b0);
      check("abort_done", bus.done, 1'b0);
      check("abort_diff", bus.diff, '0);
      check("abort_bout", bus.bout, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
      check("abort_ovf", bus.ovf, 1'b0);
`endif
      dc0 = done_cnt;
      repeat (3) @(negedge clk);
      rst_n   = 1'b1;
      last_d  = '0;
      last_bo = 1'b0;
      last_ov = 1'b0;
      hold_en = 1'b1;
      repeat (W + 3) @(negedge clk);
      check("no_done_after_abort", done_cnt - dc0, 0);
      e.d  = 8'hFE;
      e.bo = 1'b1;
      e.ov = 1'b0;
      run_op(8'h03, 8'h05, 1'b0, e);

      repeat (3) @(negedge clk);
      check("final_queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
